ifq_cmd_queue: RTL and testbench

Host-side command queue sitting between the host command/query interface and the transfer buffer / TBM datapath. It assembles 8×32-bit CDB words into 256-bit commands, holds them in a slot queue with per-slot status, and dispatches them one at a time. Dispatch drives the transfer-buffer control handshake: write means transfer buffer → TBM, read means TBM → transfer buffer. The host polls per-slot status through a byte-wide query port.

---
 rtl/ifq_pkg.sv | 37 +++
 rtl/ifq_cdb_assembler.sv | 33 +++
 rtl/ifq_cmd_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_ifq_cmd_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared constants for the host command queue.
// Opcodes, slot status codes, CDB field offsets, query response layout.
package ifq_pkg;

  localparam int CDB_W  = 256;
  localparam int WORD_W = 32;

  localparam logic [7:0] OP_WRITE = 8'h40;
  localparam logic [7:0] OP_READ  = 8'h30;

  localparam int OPC_LSB = 0;
  localparam int LBA_LSB = 32;

  localparam int RSP_IDX   = 5;
  localparam int RSP_ERR   = 4;
  localparam int RSP_ST    = 2;
  localparam int RSP_FULL  = 1;
  localparam int RSP_EMPTY = 0;

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_PEND   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_DONE   = 2'b11
  } slot_st_e;

  typedef enum logic {
    DS_IDLE,
    DS_XFER
  } disp_st_e;

  // 16 rows of 256 bits per 512 B sector
  function automatic logic [31:0] tbm_row(input logic [31:0] lba);
    return {lba[27:0], 4'b0000};
  endfunction

endpackage

// File: rtl/ifq_cdb_assembler.sv
// ifq_cdb_assembler: collects 8 consecutive 32-bit CDB words.
// cdb_valid pulses combinationally with the 8th word.
module ifq_cdb_assembler
  import ifq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdq_select,
  input  logic [WORD_W-1:0] cmd_in,
  output logic              cdb_valid,
  output logic [CDB_W-1:0]  cdb
);

  logic [2:0]              r_row;
  logic [CDB_W-WORD_W-1:0] r_sh;

  // word0 ends up in the low bits after seven shifts
  always_ff @(posedge clock) begin
    if (reset) begin
      r_row <= '0;
      r_sh  <= '0;
    end else if (cmdq_select) begin
      r_row <= r_row + 3'd1;
      r_sh  <= {cmd_in, r_sh[CDB_W-WORD_W-1:WORD_W]};
    end else begin
      r_row <= '0;
    end
  end

  assign cdb_valid = cmdq_select && (r_row == 3'd7);
  assign cdb       = {cmd_in, r_sh};

endmodule

// File: rtl/ifq_cmd_queue.sv
// ifq_cmd_queue: CDB slot queue, dispatch FSM and status query port.
// IFQ_EXT_STATUS_EN enables external DONE writes via status_update_enable.
module ifq_cmd_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmdq_select,
  input  logic [31:0]  cmd_in,
  input  logic         queryin_select,
  output logic         queryout_select,
  inout  wire  [7:0]   querydata_inout,
  output logic         sq_select,
  output logic [255:0] cmd_out,
  input  logic         status_update_enable,
  input  logic [7:0]   cmdq_index,
  output logic         xfer_buf_select,
  output logic         mwrite_enable,
  output logic [31:0]  tbm_address,
  input  logic         xfer_complete
);

  logic             w_cdb_valid;
  logic [CDB_W-1:0] w_cdb;

  ifq_cdb_assembler u_asm (
    .clock       (clock),
    .reset       (reset),
    .cmdq_select (cmdq_select),
    .cmd_in      (cmd_in),
    .cdb_valid   (w_cdb_valid),
    .cdb         (w_cdb)
  );

  slot_st_e         r_st   [DEPTH];
  logic [DEPTH-1:0] r_err;
  logic [CDB_W-1:0] r_mem  [DEPTH];
  logic [IDXW-1:0]  r_fifo [DEPTH];
  logic [IDXW-1:0]  r_wp;
  logic [IDXW-1:0]  r_rp;
  logic [IDXW:0]    r_cnt;
  logic [IDXW-1:0]  r_act;
  disp_st_e         r_ds;
  disp_st_e         w_ds_nxt;

  logic             r_qv;
  logic [7:0]       r_qb;
  logic             r_sq;
  logic             r_xb;
  logic             r_mw;
  logic [CDB_W-1:0] r_cmd;
  logic [31:0]      r_tbm;

  logic [IDXW-1:0]  w_qidx;
  logic [2:0]       w_qidx3;
  logic             w_qfree;
  logic             w_found;
  logic [IDXW-1:0]  w_fidx;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_xdone;
  logic             w_abort;
  logic [IDXW-1:0]  w_head;
  logic [CDB_W-1:0] w_hcdb;
  logic [7:0]       w_op;
  logic             w_known;
  logic [7:0]       w_rsp;
  logic             w_unused;

  assign w_qidx  = querydata_inout[IDXW-1:0];
  assign w_qidx3 = 3'(w_qidx);
  assign w_qfree = queryin_select && (r_st[w_qidx] == ST_DONE);

  // a slot freed by this cycle's query is already allocatable
  always_comb begin
    w_found = 1'b0;
    w_fidx  = '0;
    w_full  = 1'b1;
    w_empty = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_st[i] == ST_FREE || (w_qfree && w_qidx == IDXW'(i))) begin
        w_found = 1'b1;
        w_fidx  = IDXW'(i);
      end
      if (r_st[i] == ST_FREE) w_full = 1'b0;
      else w_empty = 1'b0;
    end
  end

  assign w_push  = w_cdb_valid && w_found;
  assign w_head  = r_fifo[r_rp];
  assign w_hcdb  = r_mem[w_head];
  assign w_op    = w_hcdb[OPC_LSB +: 8];
  assign w_known = (w_op == OP_WRITE) || (w_op == OP_READ);

`ifdef IFQ_EXT_STATUS_EN
  assign w_abort = status_update_enable && (r_ds == DS_XFER) &&
                   (cmdq_index[IDXW-1:0] == r_act);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_ds_nxt = r_ds;
    w_pop    = 1'b0;
    w_xdone  = 1'b0;
    unique case (r_ds)
      DS_IDLE: begin
        if (r_cnt != '0) begin
          w_pop = 1'b1;
          if (w_known) w_ds_nxt = DS_XFER;
        end
      end
      DS_XFER: begin
        if (xfer_complete || w_abort) begin
          w_xdone  = 1'b1;
          w_ds_nxt = DS_IDLE;
        end
      end
      default: w_ds_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_ds <= DS_IDLE;
    else r_ds <= w_ds_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= ST_FREE;
      r_err <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_qfree) begin
        r_st[w_qidx]  <= ST_FREE;
        r_err[w_qidx] <= 1'b0;
      end
      if (w_xdone) r_st[r_act] <= ST_DONE;
      if (w_pop) begin
        r_rp          <= r_rp + 1'b1;
        r_st[w_head]  <= w_known ? ST_ACTIVE : ST_DONE;
        r_err[w_head] <= !w_known;
      end
      if (w_push) begin
        r_st[w_fidx]  <= ST_PEND;
        r_err[w_fidx] <= 1'b0;
        r_wp          <= r_wp + 1'b1;
      end
`ifdef IFQ_EXT_STATUS_EN
      if (status_update_enable) r_st[cmdq_index[IDXW-1:0]] <= ST_DONE;
`endif
      r_cnt <= r_cnt + {{IDXW{1'b0}}, w_push} - {{IDXW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[w_fidx] <= w_cdb;
      r_fifo[r_wp]  <= w_fidx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sq  <= 1'b0;
      r_xb  <= 1'b0;
      r_mw  <= 1'b0;
      r_cmd <= '0;
      r_tbm <= '0;
      r_act <= '0;
    end else if (w_pop && w_known) begin
      r_sq  <= 1'b1;
      r_xb  <= 1'b1;
      r_mw  <= (w_op == OP_WRITE);
      r_cmd <= w_hcdb;
      r_tbm <= tbm_row(w_hcdb[LBA_LSB +: 32]);
      r_act <= w_head;
    end else if (w_xdone) begin
      r_sq <= 1'b0;
      r_xb <= 1'b0;
      r_mw <= 1'b0;
    end
  end

  always_comb begin
    w_rsp                = '0;
    w_rsp[RSP_IDX +: 3]  = w_qidx3;
    w_rsp[RSP_ERR]       = r_err[w_qidx];
    w_rsp[RSP_ST +: 2]   = r_st[w_qidx];
    w_rsp[RSP_FULL]      = w_full;
    w_rsp[RSP_EMPTY]     = w_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_qv <= 1'b0;
      r_qb <= '0;
    end else begin
      r_qv <= queryin_select;
      r_qb <= w_rsp;
    end
  end

  assign querydata_inout = r_qv ? r_qb : 8'bzzzz_zzzz;
  assign queryout_select = r_qv;
  assign sq_select       = r_sq;
  assign cmd_out         = r_cmd;
  assign xfer_buf_select = r_xb;
  assign mwrite_enable   = r_mw;
  assign tbm_address     = r_tbm;

  assign w_unused = ^{status_update_enable, cmdq_index,
                      querydata_inout[7:IDXW]};

endmodule

// File: tb/tb_ifq_cmd_queue.sv
// tb_ifq_cmd_queue: scoreboard bench with a queue-based reference model.
// Directed scenarios followed by a randomized phase.
module tb_ifq_cmd_queue;

  localparam int DEPTH = 8;

  logic         clock;
  logic         reset;
  logic         cmdq_select;
  logic [31:0]  cmd_in;
  logic         queryin_select;
  logic         queryout_select;
  wire  [7:0]   qbus;
  logic         sq_select;
  logic [255:0] cmd_out;
  logic         status_update_enable;
  logic [7:0]   cmdq_index;
  logic         xfer_buf_select;
  logic         mwrite_enable;
  logic [31:0]  tbm_address;
  logic         xfer_complete;

  logic         tb_drv;
  logic [7:0]   tb_q;

  assign qbus = tb_drv ? tb_q : 8'bzzzz_zzzz;

  ifq_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clock                (clock),
    .reset                (reset),
    .cmdq_select          (cmdq_select),
    .cmd_in               (cmd_in),
    .queryin_select       (queryin_select),
    .queryout_select      (queryout_select),
    .querydata_inout      (qbus),
    .sq_select            (sq_select),
    .cmd_out              (cmd_out),
    .status_update_enable (status_update_enable),
    .cmdq_index           (cmdq_index),
    .xfer_buf_select      (xfer_buf_select),
    .mwrite_enable        (mwrite_enable),
    .tbm_address          (tbm_address),
    .xfer_complete        (xfer_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [255:0] cmd;
    logic [31:0]  tbm;
    logic         mw;
  } xfer_t;

  int n_chk;
  int n_fail;

  logic [7:0] exp_q[$];
  xfer_t      exp_x[$];
  logic [7:0] last_q;
  bit         mon_en;
  logic       prev_xb;

  // reference model: slot table, dispatch order queue, word collector
  bit [1:0]     m_st [DEPTH];
  bit           m_err[DEPTH];
  logic [255:0] m_cdb[DEPTH];
  int           m_dq[$];
  logic [31:0]  m_words[$];
  bit           m_busy;
  int           m_act;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void model_step(bit sel, logic [31:0] w, bit qs,
                                     logic [7:0] qb, bit xc, bit rst);
    bit full;
    bit empty;
    bit pre_busy;
    int pre_n;
    int idx;
    int h;
    logic [7:0] op;
    logic [2:0] i3;
    logic [255:0] c;
    xfer_t x;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_st[i] = 2'b00;
        m_err[i] = 1'b0;
      end
      m_dq.delete();
      m_words.delete();
      m_busy = 1'b0;
      exp_q.delete();
      exp_x.delete();
      return;
    end
    full = 1'b1;
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (m_st[i] == 2'b00) full = 1'b0;
      else empty = 1'b0;
    idx = int'(qb) % DEPTH;
    if (qs) begin
      i3 = 3'(idx);
      exp_q.push_back({i3, m_err[idx], m_st[idx], full, empty});
    end
    pre_busy = m_busy;
    pre_n = m_dq.size();
    if (qs && m_st[idx] == 2'b11) begin
      m_st[idx] = 2'b00;
      m_err[idx] = 1'b0;
    end
    if (m_busy && xc) begin
      m_st[m_act] = 2'b11;
      m_busy = 1'b0;
    end
    if (!pre_busy && pre_n > 0) begin
      h = m_dq.pop_front();
      op = m_cdb[h][7:0];
      if (op == 8'h40 || op == 8'h30) begin
        m_st[h] = 2'b10;
        m_busy = 1'b1;
        m_act = h;
        x.cmd = m_cdb[h];
        x.tbm = m_cdb[h][63:32] * 32'd16;
        x.mw = (op == 8'h40);
        exp_x.push_back(x);
      end else begin
        m_st[h] = 2'b11;
        m_err[h] = 1'b1;
      end
    end
    if (sel) begin
      m_words.push_back(w);
      if (m_words.size() == 8) begin
        for (int k = 0; k < 8; k++) c[k*32 +: 32] = m_words[k];
        for (int i = 0; i < DEPTH; i++)
          if (m_st[i] == 2'b00) begin
            m_st[i] = 2'b01;
            m_err[i] = 1'b0;
            m_cdb[i] = c;
            m_dq.push_back(i);
            break;
          end
        m_words.delete();
      end
    end else begin
      m_words.delete();
    end
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        last_q = qbus;
        chk("qvalid", 256'(queryout_select), 256'(1'b1));
        chk("qbyte", 256'(qbus), 256'(exp_q.pop_front()));
      end else begin
        chk("qidle", 256'(queryout_select), 256'(1'b0));
      end
      chk("xbuf_lvl", 256'(xfer_buf_select), 256'(m_busy));
      chk("sq_lvl", 256'(sq_select), 256'(m_busy));
      if (!m_busy) chk("mw_idle", 256'(mwrite_enable), 256'(1'b0));
      if (xfer_buf_select && !prev_xb) begin
        if (exp_x.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL xfer_start actual=asserted required=none");
        end else begin
          xfer_t x;
          x = exp_x.pop_front();
          chk("cmd_out", cmd_out, x.cmd);
          chk("tbm_addr", 256'(tbm_address), 256'(x.tbm));
          chk("mwrite", 256'(mwrite_enable), 256'(x.mw));
        end
      end
      prev_xb = xfer_buf_select;
    end
  end

  task automatic cyc(input bit sel, input logic [31:0] w, input bit qs,
                     input logic [7:0] qb, input bit xc, input bit rst);
    cmdq_select = sel;
    cmd_in = w;
    queryin_select = qs;
    tb_q = qb;
    tb_drv = qs;
    xfer_complete = xc;
    reset = rst;
    @(posedge clock);
    model_step(sel, w, qs, qb, xc, rst);
    #1;
    cmdq_select = 1'b0;
    queryin_select = 1'b0;
    tb_drv = 1'b0;
    xfer_complete = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic query(input logic [7:0] q);
    cyc(1'b0, 32'h0, 1'b1, q, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic complete();
    cyc(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic send_cdb(input logic [7:0] op, input logic [31:0] lba);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] w;
      w = $urandom;
      if (k == 0) w[7:0] = op;
      if (k == 1) w = lba;
      if (k == 3) w = 32'h0100_0008;
      cyc(1'b1, w, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_xbuf"}, 256'(xfer_buf_select), 256'(1'b0));
    chk({tag, "_sq"}, 256'(sq_select), 256'(1'b0));
    chk({tag, "_mw"}, 256'(mwrite_enable), 256'(1'b0));
    chk({tag, "_tbm"}, 256'(tbm_address), 256'(0));
    chk({tag, "_cmd"}, cmd_out, 256'(0));
    chk({tag, "_qv"}, 256'(queryout_select), 256'(1'b0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    mon_en = 1'b0;
    prev_xb = 1'b0;
    last_q = 8'h00;
    tb_drv = 1'b0;
    tb_q = 8'h00;
    status_update_enable = 1'b0;
    cmdq_index = 8'h00;
    cyc(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    mon_en = 1'b1;
    chk_zero_outs("reset");

    for (int i = 0; i < 4; i++) begin
      query(8'h00);
      chk("empty_q", 256'(last_q), 256'(8'h01));
    end

    send_cdb(8'h40, 32'h0);
    idle(1);
    chk("wr_xbuf", 256'(xfer_buf_select), 256'(1'b1));
    chk("wr_mw", 256'(mwrite_enable), 256'(1'b1));
    chk("wr_tbm", 256'(tbm_address), 256'(0));
    idle(19);
    complete();
    query(8'h00);
    chk("wr_done", 256'(last_q[3:2]), 256'(2'b11));
    query(8'h00);
    chk("wr_freed", 256'(last_q[3:2]), 256'(2'b00));

    send_cdb(8'h30, 32'h5);
    idle(1);
    chk("rd_mw", 256'(mwrite_enable), 256'(1'b0));
    chk("rd_tbm", 256'(tbm_address), 256'(32'h50));
    query(8'h00);
    chk("rd_active", 256'(last_q[3:2]), 256'(2'b10));
    complete();
    query(8'h00);
    chk("rd_done", 256'(last_q[3:2]), 256'(2'b11));
    query(8'h00);

    for (int k = 0; k < 5; k++) cyc(1'b1, $urandom, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    send_cdb(8'h40, 32'h123);
    idle(1);
    chk("part_tbm", 256'(tbm_address), 256'(32'h1230));
    query(8'h01);
    chk("part_slot1", 256'(last_q[3:2]), 256'(2'b00));
    complete();
    query(8'h00);

    for (int n = 0; n < 9; n++) send_cdb(8'h40, 32'(n * 3));
    query(8'h00);
    chk("full_bit", 256'(last_q[1]), 256'(1'b1));
    query(8'h07);
    chk("slot7_pend", 256'(last_q[3:2]), 256'(2'b01));
    repeat (8) begin
      complete();
      idle(2);
    end
    for (int i = 0; i < DEPTH; i++) query(8'(i));

    send_cdb(8'h12, 32'h9);
    idle(2);
    query(8'h00);
    chk("bad_err", 256'(last_q[4]), 256'(1'b1));
    chk("bad_done", 256'(last_q[3:2]), 256'(2'b11));
    query(8'h00);

    send_cdb(8'h30, 32'h7);
    idle(2);
    chk("pre_rst_xbuf", 256'(xfer_buf_select), 256'(1'b1));
    cyc(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_zero_outs("midrst");
    query(8'h00);
    chk("rst_q", 256'(last_q), 256'(8'h01));

    begin
      int k;
      bit pq;
      k = 0;
      pq = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        bit sel;
        bit qs;
        bit xc;
        bit rs;
        logic [31:0] w;
        if (k != 0) sel = ($urandom_range(0, 19) != 0);
        else sel = ($urandom_range(0, 3) == 0);
        w = $urandom;
        if (sel && k == 0) begin
          case ($urandom_range(0, 4))
            0, 1: w[7:0] = 8'h40;
            2, 3: w[7:0] = 8'h30;
            default: w[7:0] = 8'($urandom);
          endcase
        end
        qs = !pq && ($urandom_range(0, 4) == 0);
        xc = ($urandom_range(0, 9) == 0);
        rs = ($urandom_range(0, 499) == 0);
        if (rs) begin
          sel = 1'b0;
          qs = 1'b0;
        end
        k = sel ? (k + 1) % 8 : 0;
        pq = qs;
        cyc(sel, w, qs, 8'($urandom), xc, rs);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
